uart_transmitter: RTL and testbench

- 8N1 UART transmitter. The transmit-side counterpart of the serial receiver on the same link.
- Accepts one byte per valid/ready handshake from the local logic. Serialises it on uart_txd as start bit, 8 data bits LSB first, then stop bit.
- Drives the board TX pin directly. Bit timing is derived from the system clock by a cycle counter.

---
 rtl/uart_transmitter.sv | 144 ++++++++++++++
 tb/tb_uart_transmitter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one byte per tx_start/tx_ready handshake, serialised LSB first on uart_txd.
// Latency: start bit driven from the acceptance edge; frame is 10 bit periods (11 with UART_TX_PARITY_EN).
// Backpressure: tx_ready low while a frame is in flight; tx_start is ignored then (no queueing).
// Optional feature macro: UART_TX_PARITY_EN adds an even parity bit between the data and stop bits.
module uart_transmitter #(
    parameter int SYS_PERIOD = 100_000_000,
    parameter int BPS        = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);

    // Clock cycles per bit; truncating division, valid range 2..65535.
    localparam int          BIT_PERIOD = SYS_PERIOD / BPS;
    localparam logic [15:0] BP_LAST    = 16'(BIT_PERIOD - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic        r_ready;
    logic        r_done;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    // Last cycle of the current bit period.
    logic w_wrap;
    assign w_wrap = (r_cnt == BP_LAST);

    // Frame sequencer: bit timing counter, bit index, shift register and registered line driver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 16'd0;
            r_idx    <= 3'd0;
            r_shift  <= 8'd0;
            r_txd    <= 1'b1;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 16'd0;
                    r_idx <= 3'd0;
                    r_txd <= 1'b1;
                    if (tx_start && r_ready) begin
                        r_shift  <= tx_data;
                        r_txd    <= 1'b0;
                        r_ready  <= 1'b0;
                        r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^tx_data;
`endif
                    end
                end
                S_START: begin
                    if (w_wrap) begin
                        r_cnt   <= 16'd0;
                        r_txd   <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_wrap) begin
                        r_cnt <= 16'd0;
                        if (r_idx == 3'd7) begin
                            r_idx   <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            r_txd   <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_txd   <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_wrap) begin
                        r_cnt   <= 16'd0;
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_wrap) begin
                        r_cnt   <= 16'd0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_cnt   <= 16'd0;
                    r_idx   <= 3'd0;
                    r_txd   <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign tx_busy  = ~r_ready;
    assign tx_done  = r_done;
    assign uart_txd = r_txd;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomised self-checking bench for uart_transmitter at BP=10 cycles per bit.
// Expected line levels come from a per-frame bit list built from the byte.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_transmitter;

    localparam int BP = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * BP;

    logic       clk;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       uart_txd;

    int checks = 0;
    int errors = 0;

    uart_transmitter #(.SYS_PERIOD(1000), .BPS(100)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .uart_txd (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level for each bit slot of a frame: start, data LSB first, [even parity], stop.
    function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
        logic [NB-1:0] m;
        m = '0;
        m[0] = 1'b0;
        for (int i = 0; i < 8; i++) m[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        m[9] = ($countones(d) % 2) == 1;
`endif
        m[NB-1] = 1'b1;
        return m;
    endfunction

    // Idle cycles: line high, ready, no done pulse.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_txd", uart_txd, 1);
            chk("idle_ready", tx_ready, 1);
            chk("idle_done", tx_done, 0);
        end
    endtask

    // Send one byte starting at the current falling edge. hold keeps tx_start high across
    // the frame and past tx_done; coll >= 2 injects a one-cycle request while busy.
    task automatic run_frame(input logic [7:0] d, input bit hold, input int coll);
        logic [NB-1:0] bits;
        int nbad;
        chk("pre_ready", tx_ready, 1);
        bits = frame_bits(d);
        tx_start = 1'b1;
        tx_data  = d;
        @(posedge clk);
        nbad = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            chk($sformatf("txd_%02h_c%0d", d, k), uart_txd, bits[k/BP]);
            if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) nbad++;
            if (k == 0 && !hold) tx_start = 1'b0;
            if (k == 1) tx_data = 8'($urandom);
            if (coll >= 2 && k == coll) begin
                tx_start = 1'b1;
                tx_data  = ~d;
            end else if (coll >= 2 && k == coll + 1 && !hold) begin
                tx_start = 1'b0;
            end
        end
        chk("inflight_flags", nbad, 0);
        @(negedge clk);
        chk("done_pulse", tx_done, 1);
        chk("ready_end", tx_ready, 1);
        chk("busy_end", tx_busy, 0);
        chk("gap_txd", uart_txd, 1);
        if (!hold) tx_start = 1'b0;
    endtask

    // Abort a frame with an asynchronous reset between clock edges, then send a recovery byte.
    task automatic reset_mid(input logic [7:0] d, input int cyc);
        logic [NB-1:0] bits;
        bits = frame_bits(d);
        tx_start = 1'b1;
        tx_data  = d;
        @(posedge clk);
        for (int k = 0; k < cyc; k++) begin
            @(negedge clk);
            if (k == 0) tx_start = 1'b0;
            chk("pre_abort_txd", uart_txd, bits[k/BP]);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_txd", uart_txd, 1);
        chk("abort_ready", tx_ready, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_done", tx_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        run_frame(8'h55, 1'b0, -1);
        idle(1);
    endtask

    initial begin
        bit hold;
        int coll;
        logic [7:0] d;
        rst_n    = 1'b0;
        tx_start = 1'b1;
        tx_data  = 8'hA5;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_txd", uart_txd, 1);
            chk("rst_ready", tx_ready, 1);
            chk("rst_busy", tx_busy, 0);
            chk("rst_done", tx_done, 0);
        end
        tx_start = 1'b0;
        rst_n    = 1'b1;
        idle(3);

        // Single byte.
        run_frame(8'hA5, 1'b0, -1);
        idle(3);
        // Back-to-back: request held high, data switched at tx_done.
        run_frame(8'h00, 1'b1, -1);
        run_frame(8'hFF, 1'b0, -1);
        idle(2);
        // Request while busy is ignored.
        run_frame(8'h3C, 1'b0, 45);
        idle(5);
        // Parity-sensitive bytes (odd and even weight).
        run_frame(8'h07, 1'b0, -1);
        idle(1);
        run_frame(8'h03, 1'b0, -1);
        idle(2);
        // Reset mid-frame: once on a high data bit, once during a low bit and the start bit.
        reset_mid(8'h0F, 35);
        reset_mid(8'hF0, 35);
        reset_mid(8'hA5, 5);

        // Randomised traffic.
        hold = 1'b0;
        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom);
            hold = 1'($urandom_range(0, 1));
            coll = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, FRAME - 2)) : -1;
            run_frame(d, hold, coll);
            if (!hold) idle(int'($urandom_range(0, 3)));
        end
        run_frame(8'h5A, 1'b0, -1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
